boreal_sram_tile_mp: RTL and testbench
======================================

BOREAL_SRAM_TILE_MP -- requirements
Module: boreal_sram_tile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, words stored (power of two).
REQ-003 SHALL have parameter STARVE_LIM, default 4, maximum consecutive denied cycles for the DMA port (1..15).
REQ-004 SHALL derive localparams AW=log2(DEPTH), NB=DATA_W/8, BW=log2(NB).
REQ-005 SHALL have ports clk input 1 (clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have bus-port inputs: b_req 1, b_wr 1, b_addr 32 (byte address), b_wdata DATA_W, b_strb NB.
REQ-007 SHALL have bus-port outputs: b_gnt 1 (combinational accept), b_ack 1, b_rdata DATA_W, b_err 1.
REQ-008 SHALL have DMA-port inputs: d_req 1, d_wr 1, d_addr AW (word address), d_wdata DATA_W, d_strb NB.
REQ-009 SHALL have DMA-port outputs: d_gnt 1, d_ack 1, d_rdata DATA_W.
REQ-010 SHALL have output par_err 1, a read parity error flag.

Function
REQ-011 SHALL be single-ported storage with at most one access (read or write) per cycle.
REQ-012 SHALL keep each requester's request fields stable while req=1 and gnt=0; a transfer occurs on a cycle with req=1 and gnt=1.
REQ-013 SHALL arbitrate as follows: bus wins by default; DMA wins when only d_req is set or when wait_cnt==STARVE_LIM.
REQ-014 SHALL handle wait_cnt (4 bits) as: increment on d_req&&!d_gnt; clear on d_gnt or !d_req; saturate at STARVE_LIM.
REQ-015 SHALL apply byte-lane strobe writes on both ports, with strb lane i covering bits [8i+7:8i]; strb=0 writes nothing but still acks.
REQ-016 SHALL decode the bus word index as b_addr[AW+BW-1:BW] and ignore b_addr[BW-1:0].
REQ-017 SHALL treat a granted bus access with b_addr[31:AW+BW]!=0 as out of range: no write, b_rdata=0, b_err=1 with b_ack.
REQ-018 SHALL assert ack exactly one cycle after grant for one cycle, for reads and writes alike.
REQ-019 SHALL return read data with ack; rdata SHALL be 0 whenever ack=0 or the access was a write.
REQ-020 SHALL make a read in cycle N+1 return data written in cycle N to the same word.
REQ-021 SHALL allow back-to-back grants each cycle, giving full throughput per port.

Reset
REQ-022 SHALL, while rst_n=0, drive b_ack, d_ack, b_err and par_err to 0, b_rdata and d_rdata to 0, and wait_cnt to 0.
REQ-023 SHALL drop an ack pending across a reset assertion; memory contents SHALL NOT be reset.
REQ-024 SHALL hold b_gnt and d_gnt at 0 while rst_n=0.

Configuration
REQ-025 SHALL, when macro BOREAL_SRAM_PARITY_EN is defined, store one even-parity bit per byte, update it on each strobed byte write, check it on reads, and assert par_err with the ack of a read that mismatches on any byte.
REQ-026 SHALL, when BOREAL_SRAM_PARITY_EN is undefined, add no parity storage and tie par_err to 0.

Structure
REQ-027 SHALL place the localparam width helpers and the STARVE_LIM bound constant in shared package boreal_sram_pkg.
REQ-028 SHALL implement arbitration and wait_cnt in sub-module boreal_sram_arb; storage, strobes and parity SHALL reside in the top module.

Verification
REQ-029 SHALL verify: bus write 0xDEADBEEF strb=4'b1111 to byte address 0x10, then bus read 0x10 -> b_ack one cycle after grant, b_rdata=0xDEADBEEF.
REQ-030 SHALL verify: write 0x11223344 then strb=4'b0100 data 0xAABBCCDD to the same word, then read -> 0x11BB3344.
REQ-031 SHALL verify: b_req and d_req both held high continuously with STARVE_LIM=4 -> d_gnt exactly once every 5 cycles, b_gnt on the other 4.
REQ-032 SHALL verify: bus read at b_addr=0x1000 with DEPTH=1024 -> b_err=1, b_rdata=0, memory unchanged.
REQ-033 SHALL verify: rst_n deasserted the cycle after a grant -> no ack follows, all outputs 0 during reset, and data written before reset reads back unchanged afterward.
REQ-034 SHALL verify, with BOREAL_SRAM_PARITY_EN defined: force the stored parity bit of byte 2 of word 5, then DMA read word 5 -> par_err=1 with d_ack; without the macro, par_err stays 0.

Source files
------------

// File: rtl/boreal_sram_pkg.sv
// Shared constants and width helpers for the boreal SRAM tile.
//   - WAIT_CNT_W       : width of the DMA starvation counter
//   - STARVE_LIM_MIN/MAX: legal range of the STARVE_LIM parameter
//   - addr_w/lane_n/lane_w: word-address, byte-lane count and byte-offset widths
//   - port_e           : which requester owns the storage port this cycle
package boreal_sram_pkg;

  localparam int unsigned WAIT_CNT_W     = 4;
  localparam int unsigned STARVE_LIM_MIN = 1;
  localparam int unsigned STARVE_LIM_MAX = 15;

  typedef enum logic [0:0] {
    PortBus = 1'b0,
    PortDma = 1'b1
  } port_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned lane_n(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned lane_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/boreal_sram_arb.sv
// Two-requester arbiter for the boreal SRAM tile.
// The bus port wins by default; the DMA port wins when it requests alone or
// once it has been denied STARVE_LIM consecutive cycles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_b_req, i_d_req    : bus / DMA requests
//   o_b_gnt, o_d_gnt    : combinational grants (both 0 while in reset)
module boreal_sram_arb
  import boreal_sram_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_b_req,
  input  logic i_d_req,
  output logic o_b_gnt,
  output logic o_d_gnt
);

  localparam logic [WAIT_CNT_W-1:0] Lim = WAIT_CNT_W'(STARVE_LIM);

  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_d;
  logic                  w_d_win;

  assign w_d_win = i_d_req && (!i_b_req || (r_wait_cnt == Lim));
  assign o_d_gnt = rst_n && w_d_win;
  assign o_b_gnt = rst_n && i_b_req && !w_d_win;

  always_comb begin
    w_wait_cnt_d = r_wait_cnt;
    if (!i_d_req || o_d_gnt) begin
      w_wait_cnt_d = '0;
    end else if (r_wait_cnt < Lim) begin
      w_wait_cnt_d = r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_d;
    end
  end

endmodule

// File: rtl/boreal_sram_tile_mp.sv
// Single-ported SRAM tile shared by a byte-addressed bus port and a
// word-addressed DMA port. One access per cycle; ack and read data follow a
// grant by exactly one cycle. Bus accesses above the tile window are flagged
// with b_err and never touch storage.
// Optional feature: define BOREAL_SRAM_PARITY_EN to keep one even-parity bit
// per byte, checked on reads and reported on par_err alongside the ack.
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   b_req/b_wr/b_addr/b_wdata/b_strb        : bus request (byte address)
//   b_gnt/b_ack/b_rdata/b_err               : bus grant, ack, read data, range error
//   d_req/d_wr/d_addr/d_wdata/d_strb        : DMA request (word address)
//   d_gnt/d_ack/d_rdata                     : DMA grant, ack, read data
//   par_err                                 : read parity error, valid with ack
module boreal_sram_tile_mp
  import boreal_sram_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_LIM = 4,
  localparam int unsigned AW = addr_w(DEPTH),
  localparam int unsigned NB = lane_n(DATA_W),
  localparam int unsigned BW = lane_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [NB-1:0]     b_strb,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [NB-1:0]     d_strb,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              par_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [31:0]       w_b_hi;
  logic              w_b_oor;
  port_e             w_sel;
  logic              w_acc;
  logic              w_wr;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_strb;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_b_ack;
  logic              r_b_err;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_d_rdata;

  boreal_sram_arb #(
    .STARVE_LIM(STARVE_LIM)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_b_req(b_req),
    .i_d_req(d_req),
    .o_b_gnt(b_gnt),
    .o_d_gnt(d_gnt)
  );

  // Any set bit above the tile window makes the bus access out of range.
  assign w_b_hi  = b_addr >> (AW + BW);
  assign w_b_oor = |w_b_hi;

  always_comb begin
    w_sel   = d_gnt ? PortDma : PortBus;
    w_acc   = d_gnt || (b_gnt && !w_b_oor);
    w_wr    = (w_sel == PortDma) ? d_wr : b_wr;
    w_idx   = (w_sel == PortDma) ? d_addr : b_addr[AW+BW-1:BW];
    w_wdata = (w_sel == PortDma) ? d_wdata : b_wdata;
    w_strb  = (w_sel == PortDma) ? d_strb : b_strb;
  end

  assign w_rd_word = r_mem[w_idx];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc && w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_b_ack   <= b_gnt;
      r_b_err   <= b_gnt && w_b_oor;
      r_b_rdata <= (b_gnt && !b_wr && !w_b_oor) ? w_rd_word : '0;
      r_d_ack   <= d_gnt;
      r_d_rdata <= (d_gnt && !d_wr) ? w_rd_word : '0;
    end
  end

  assign b_ack   = r_b_ack;
  assign b_err   = r_b_err;
  assign b_rdata = r_b_rdata;
  assign d_ack   = r_d_ack;
  assign d_rdata = r_d_rdata;

`ifdef BOREAL_SRAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic          w_par_bad;
  logic          r_par_err;

  always_ff @(posedge clk) begin
    if (w_acc && w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb[i]) begin
          r_par[w_idx][i] <= ^w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Even parity: stored bit equals the XOR of the byte.
  always_comb begin
    w_par_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      w_par_bad = w_par_bad | ((^w_rd_word[8*i +: 8]) ^ r_par[w_idx][i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_acc && !w_wr && w_par_bad;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_boreal_sram_tile_mp.sv
// Scoreboard bench for boreal_sram_tile_mp: grants are observed and turned into
// expected responses from a word-array reference model; a separate monitor
// matches every ack against the queue for its port.
module tb_boreal_sram_tile_mp;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_req, b_wr;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_strb;
  logic        b_gnt, b_ack, b_err;
  logic [31:0] b_rdata;
  logic        d_req, d_wr;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic        d_gnt, d_ack;
  logic [31:0] d_rdata;
  logic        par_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  corrupt [DEPTH];

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        par;
  } exp_t;

  exp_t bq[$];
  exp_t dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  boreal_sram_tile_mp #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .b_req  (b_req),
    .b_wr   (b_wr),
    .b_addr (b_addr),
    .b_wdata(b_wdata),
    .b_strb (b_strb),
    .b_gnt  (b_gnt),
    .b_ack  (b_ack),
    .b_rdata(b_rdata),
    .b_err  (b_err),
    .d_req  (d_req),
    .d_wr   (d_wr),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_strb (d_strb),
    .d_gnt  (d_gnt),
    .d_ack  (d_ack),
    .d_rdata(d_rdata),
    .par_err(par_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_write(input int idx, input logic [31:0] wd, input logic [3:0] st);
    for (int i = 0; i < 4; i++) begin
      if (st[i]) begin
        ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
        corrupt[idx][i] = 1'b0;
      end
    end
  endfunction

  // Grant observer: every transfer becomes one expected response.
  always @(negedge clk) begin
    exp_t be, de;
    int   bi, di;
    if (rst_n) begin
      chk("gnt_exclusive", {62'd0, b_gnt, d_gnt} == 64'd3, 64'd0);
      if (b_gnt) begin
        be.cyc = cyc; be.rdata = '0; be.err = 1'b0; be.par = 1'b0;
        // 1024 words x 4 bytes = 4 KiB window
        if ((b_addr >> 12) != 32'd0) begin
          be.err = 1'b1;
        end else begin
          bi = int'(b_addr[11:2]);
          if (b_wr) model_write(bi, b_wdata, b_strb);
          else begin
            be.rdata = ref_mem[bi];
            be.par   = |corrupt[bi];
          end
        end
        bq.push_back(be);
      end
      if (d_gnt) begin
        de.cyc = cyc; de.rdata = '0; de.err = 1'b0; de.par = 1'b0;
        di = int'(d_addr);
        if (d_wr) model_write(di, d_wdata, d_strb);
        else begin
          de.rdata = ref_mem[di];
          de.par   = |corrupt[di];
        end
        dq.push_back(de);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_ctrl_outs", {58'd0, b_gnt, d_gnt, b_ack, d_ack, b_err, par_err}, 64'd0);
      chk("reset_b_rdata", b_rdata, 64'd0);
      chk("reset_d_rdata", d_rdata, 64'd0);
      bq.delete();
      dq.delete();
    end else begin
      if (b_ack) begin
        if (bq.size() == 0) begin
          chk("b_ack_unexpected", 1, 0);
        end else begin
          e = bq.pop_front();
          chk("b_ack_latency", cyc, e.cyc + 1);
          chk("b_rdata", b_rdata, e.rdata);
          chk("b_err", b_err, e.err);
          chk("b_par_err", par_err, e.par);
        end
      end else begin
        chk("b_idle_rdata", b_rdata, 64'd0);
        chk("b_idle_err", b_err, 64'd0);
        if (bq.size() > 0 && bq[0].cyc < cyc - 1) begin
          chk("b_ack_missing", 0, 1);
          void'(bq.pop_front());
        end
      end
      if (d_ack) begin
        if (dq.size() == 0) begin
          chk("d_ack_unexpected", 1, 0);
        end else begin
          e = dq.pop_front();
          chk("d_ack_latency", cyc, e.cyc + 1);
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_par_err", par_err, e.par);
        end
      end else begin
        chk("d_idle_rdata", d_rdata, 64'd0);
        if (dq.size() > 0 && dq[0].cyc < cyc - 1) begin
          chk("d_ack_missing", 0, 1);
          void'(dq.pop_front());
        end
      end
      if (!b_ack && !d_ack) chk("par_err_idle", par_err, 64'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic b_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st);
    int k = 0;
    logic g = 1'b0;
    b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd; b_strb = st;
    while (!g && k < 64) begin
      @(negedge clk);
      g = b_gnt;
      k++;
    end
    if (!g) chk("b_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    b_req = 1'b0;
  endtask

  task automatic d_op(input logic wr, input int addr, input logic [31:0] wd,
                      input logic [3:0] st);
    int k = 0;
    logic g = 1'b0;
    d_req = 1'b1; d_wr = wr; d_addr = addr[9:0]; d_wdata = wd; d_strb = st;
    while (!g && k < 64) begin
      @(negedge clk);
      g = d_gnt;
      k++;
    end
    if (!g) chk("d_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 4'h0;
    // Requests held high through reset: grants must stay low.
    rst_n = 1'b0;
    b_req = 1'b1; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_strb = '0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_strb = '0;
    repeat (3) @(posedge clk);
    #1;
    b_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int w = 0; w < 16; w++) d_op(1'b1, w, $urandom, 4'hF);

    // Full write then read-back, back to back.
    b_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    b_op(1'b0, 32'h10, 32'h0, 4'h0);

    // Single-lane strobe merge, then an all-zero strobe that must change nothing.
    b_op(1'b1, 32'h20, 32'h11223344, 4'hF);
    b_op(1'b1, 32'h22, 32'hAABBCCDD, 4'b0100);
    b_op(1'b0, 32'h23, 32'h0, 4'h0);
    b_op(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    d_op(1'b0, 8, 32'h0, 4'h0);
    chk("strobe_merge_ref", ref_mem[8], 64'h11BB3344);

    // Out-of-range read and write; word 4 must keep its value.
    b_op(1'b0, 32'h1000, 32'h0, 4'h0);
    b_op(1'b1, 32'h1010, 32'hCAFEF00D, 4'hF);
    b_op(1'b0, 32'h10, 32'h0, 4'h0);

    // Both ports requesting continuously: DMA every fifth cycle.
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h4;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 10'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("starve_d_gnt", d_gnt, (i % 5) == 4);
      chk("starve_b_gnt", b_gnt, (i % 5) != 4);
      @(posedge clk);
      #1;
    end
    b_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;

`ifdef BOREAL_SRAM_PARITY_EN
    dut.r_par[5][2] = ~dut.r_par[5][2];
    corrupt[5][2] = 1'b1;
    d_op(1'b0, 5, 32'h0, 4'h0);
    d_op(1'b1, 5, 32'h00770000, 4'b0100);
    d_op(1'b0, 5, 32'h0, 4'h0);
`endif

    // Randomised traffic on both ports concurrently.
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          logic [31:0] a;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))} << 0;
          a = {a[31:6], a[5:0]};
          a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
          b_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      begin
        for (int n = 0; n < 200; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          d_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)));
        end
      end
    join

    // Reset right after a read grant: its ack must never appear.
    b_op(1'b1, 32'h30, 32'h5A5A1234, 4'hF);
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h30;
    @(negedge clk);
    chk("rst_pre_gnt", b_gnt, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_op(1'b0, 32'h30, 32'h0, 4'h0);
    d_op(1'b0, 12, 32'h0, 4'h0);
    b_op(1'b0, 32'h20, 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    chk("drain_queues", bq.size() + dq.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
